led_display_writer: RTL and testbench

Memory-mapped output peripheral on the Nexys board bus. It is the write-side counterpart of the switch/button input peripheral: the CPU stores words to fixed addresses, and the block drives the 16 board LEDs and the 8-digit multiplexed seven-segment display. It also returns the stored values on read-back with one cycle of latency.

---
 rtl/led_display_writer_if.sv | 11 +
 rtl/led_display_writer.sv | 83 ++++++++
 tb/tb_led_display_writer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/led_display_writer_if.sv
// Bus bundle for the LED / seven-segment output peripheral.
// The CPU side (master) drives address and write data; the peripheral returns registered read data.
interface led_display_writer_if;
  logic [31:0] address;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output address, we, data_in, input data_out);
  modport slave  (input address, we, data_in, output data_out);
endinterface

// File: rtl/led_display_writer.sv
// Memory-mapped writer for the 16 board LEDs and the 8-digit multiplexed hex display,
// with registered read-back and a free-running digit scan.
module led_display_writer #(
  parameter logic [31:0] LED_ADDR    = 32'h0000_2004,
  parameter logic [31:0] SEG_ADDR    = 32'h0000_2008,
  parameter logic [31:0] DEN_ADDR    = 32'h0000_200C,
  parameter int          REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  led_display_writer_if.slave  bus,
  output logic [15:0]          leds,
  output logic [6:0]           seg,
  output logic [7:0]           an
);

  localparam int             PW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PS_MAX = PW'(REFRESH_DIV - 1);

  logic [15:0]   led_q, led_d;
  logic [31:0]   seg_q, seg_d;
  logic [7:0]    den_q, den_d;
  logic [31:0]   data_out_q, data_out_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [2:0]    digit_idx_q, digit_idx_d;

  function automatic logic [6:0] hexdec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    led_d       = led_q;
    seg_d       = seg_q;
    den_d       = den_q;
    data_out_d  = 32'h0;
    prescaler_d = (prescaler_q == PS_MAX) ? '0 : prescaler_q + PW'(1);
    // 3-bit index wraps 7 -> 0 on its own
    digit_idx_d = (prescaler_q == PS_MAX) ? digit_idx_q + 3'd1 : digit_idx_q;

    // Read-back uses the current (pre-write) register values.
    if (bus.address == LED_ADDR)      data_out_d = {16'h0, led_q};
    else if (bus.address == SEG_ADDR) data_out_d = seg_q;
    else if (bus.address == DEN_ADDR) data_out_d = {24'h0, den_q};

    if (bus.we) begin
      if (bus.address == LED_ADDR)      led_d = bus.data_in[15:0];
      else if (bus.address == SEG_ADDR) seg_d = bus.data_in;
      else if (bus.address == DEN_ADDR) den_d = bus.data_in[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q       <= 16'h0;
      seg_q       <= 32'h0;
      den_q       <= 8'hFF;
      data_out_q  <= 32'h0;
      prescaler_q <= '0;
      digit_idx_q <= 3'd0;
    end else begin
      led_q       <= led_d;
      seg_q       <= seg_d;
      den_q       <= den_d;
      data_out_q  <= data_out_d;
      prescaler_q <= prescaler_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign leds         = led_q;
  // Disabled slots blank the anodes but keep decoding the nibble onto seg.
  assign an           = den_q[digit_idx_q] ? ~(8'b1 << digit_idx_q) : 8'hFF;
  assign seg          = hexdec(seg_q[4*digit_idx_q +: 4]);

endmodule

// File: tb/tb_led_display_writer.sv
// Randomized + directed bench for led_display_writer against a cycle-count based reference model.
module tb_led_display_writer;

  localparam int          RD   = 4;
  localparam logic [31:0] LEDA = 32'h0000_2004;
  localparam logic [31:0] SEGA = 32'h0000_2008;
  localparam logic [31:0] DENA = 32'h0000_200C;

  logic        clk;
  logic        rst;
  logic [15:0] leds;
  logic [6:0]  seg;
  logic [7:0]  an;

  led_display_writer_if bus_if();

  led_display_writer #(
    .LED_ADDR(LEDA), .SEG_ADDR(SEGA), .DEN_ADDR(DENA), .REFRESH_DIV(RD)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .leds(leds), .seg(seg), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: register contents plus cycles elapsed since the last reset edge.
  logic [15:0] m_led;
  logic [31:0] m_seg;
  logic [7:0]  m_den;
  logic [31:0] m_dout;
  int          m_cyc;
  logic [6:0]  hex_tab [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == LEDA) return {16'h0, m_led};
    if (a == SEGA) return m_seg;
    if (a == DENA) return {24'h0, m_den};
    return 32'h0;
  endfunction

  // One clock: apply inputs, advance the model, then compare every output after the edge.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int         dg;
    logic [7:0] exp_an;
    logic [3:0] nib;
    rst = r; bus_if.we = w; bus_if.address = a; bus_if.data_in = d;
    if (r) begin
      m_led = 16'h0; m_seg = 32'h0; m_den = 8'hFF; m_dout = 32'h0; m_cyc = 0;
    end else begin
      m_dout = m_read(a);
      if (w) begin
        if (a == LEDA)      m_led = d[15:0];
        else if (a == SEGA) m_seg = d;
        else if (a == DENA) m_den = d[7:0];
      end
      m_cyc++;
    end
    @(posedge clk);
    #1;
    dg     = (m_cyc / RD) % 8;
    exp_an = m_den[dg] ? ~(8'd1 << dg) : 8'hFF;
    nib    = m_seg[4*dg +: 4];
    chk("leds", {16'h0, leds}, {16'h0, m_led});
    chk("an", {24'h0, an}, {24'h0, exp_an});
    chk("seg", {25'h0, seg}, {25'h0, hex_tab[nib]});
    chk("data_out", bus_if.data_out, m_dout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, LEDA, 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst = 1'b1; bus_if.we = 1'b0; bus_if.address = 32'h0; bus_if.data_in = 32'h0;

    // Reset and first slot boundary
    step(1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    chk("rst_an", {24'h0, an}, 32'h0000_00FE);
    chk("rst_seg", {25'h0, seg}, 32'h0000_0040);
    chk("rst_dout", bus_if.data_out, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    idle(2);
    chk("slot0_end_an", {24'h0, an}, 32'h0000_00FE);
    idle(1);
    chk("slot1_an", {24'h0, an}, 32'h0000_00FD);

    // LED write then read-back
    step(1'b0, 1'b1, LEDA, 32'h0000_A5C3);
    chk("led_wr", {16'h0, leds}, 32'h0000_A5C3);
    step(1'b0, 1'b0, LEDA, 32'h0);
    chk("led_rd", bus_if.data_out, 32'h0000_A5C3);

    // Display scan over a full frame, then digit-enable mask
    step(1'b0, 1'b1, SEGA, 32'h89AB_CDEF);
    idle(8 * RD + 2);
    step(1'b0, 1'b1, DENA, 32'h0000_000F);
    idle(8 * RD + 2);

    // Unmapped addresses
    step(1'b0, 1'b1, 32'h0000_2000, 32'hFFFF_FFFF);
    chk("dec_2000", bus_if.data_out, 32'h0);
    step(1'b0, 1'b1, 32'h0000_2010, 32'hFFFF_FFFF);
    chk("dec_2010", bus_if.data_out, 32'h0);
    chk("dec_leds", {16'h0, leds}, 32'h0000_A5C3);

    // Read-before-write
    step(1'b0, 1'b1, LEDA, 32'h0000_1111);
    step(1'b0, 1'b1, LEDA, 32'h0000_2222);
    chk("rbw_old", bus_if.data_out, 32'h0000_1111);
    step(1'b0, 1'b0, LEDA, 32'h0);
    chk("rbw_new", bus_if.data_out, 32'h0000_2222);

    // Reset mid-slot at digit 5, prescaler 2
    step(1'b0, 1'b1, DENA, 32'h0000_00FF);
    for (int i = 0; i < 64 && (m_cyc % (8 * RD)) != (5 * RD + 2); i++) idle(1);
    chk("reach_slot5", m_cyc % (8 * RD), 5 * RD + 2);
    step(1'b1, 1'b0, LEDA, 32'h0);
    chk("mid_rst_an", {24'h0, an}, 32'h0000_00FE);
    idle(RD - 1);
    chk("mid_rst_slot0", {24'h0, an}, 32'h0000_00FE);
    idle(1);
    chk("mid_rst_slot1", {24'h0, an}, 32'h0000_00FD);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0: ra = LEDA;
        1: ra = SEGA;
        2: ra = DENA;
        3: ra = 32'h0000_2000;
        4: ra = 32'h0000_2010;
        default: ra = $urandom;
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), ra, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
